perceptron_sequencer: RTL

Controller for a bit-serial perceptron. It owns the weight/bias register file and arbitrates between two requesters for one shared accumulate datapath. Each request is sequenced over 8 bit-serial accumulate cycles, and the signed result and class are returned on a valid/ready result port. It sits between the configuration bus, the two feature sources and the downstream classifier consumer.

---
 rtl/perceptron_pkg.sv | 19 +
 rtl/perceptron_sequencer_rr_arbiter2.sv | 57 +++++
 rtl/perceptron_sequencer.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/perceptron_pkg.sv
// Shared types and constants for the bit-serial perceptron sequencer.
// Holds the FSM state encoding, default widths and register-file reset values.
package perceptron_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int NBITS_DEF = 8;
    localparam int WW_DEF    = 8;
    localparam int ACC_W_DEF = 12;

    localparam logic [3:0] CFG_ADDR_BIAS = 4'd8;
    localparam logic [7:0] W_RESET       = 8'h40;
    localparam logic [7:0] B_RESET       = 8'h00;

endpackage

// File: rtl/perceptron_sequencer_rr_arbiter2.sv
// Two-requester round-robin arbiter: grants only while en is high and moves
// preference to the other requester whenever a grant is issued.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);

    logic ptr_q;
    logic ptr_d;

    // Grant selection from the preference pointer, plus pointer advance
    always_comb begin
        gnt   = 2'b00;
        ptr_d = ptr_q;
        if (en) begin
            if (ptr_q == 1'b0) begin
                if (req[0]) begin
                    gnt = 2'b01;
                end else if (req[1]) begin
                    gnt = 2'b10;
                end else begin
                    gnt = 2'b00;
                end
            end else begin
                if (req[1]) begin
                    gnt = 2'b10;
                end else if (req[0]) begin
                    gnt = 2'b01;
                end else begin
                    gnt = 2'b00;
                end
            end
        end else begin
            gnt = 2'b00;
        end
        if (gnt[0]) begin
            ptr_d = 1'b1;
        end else if (gnt[1]) begin
            ptr_d = 1'b0;
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Preference pointer register; requester 0 preferred out of reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/perceptron_sequencer.sv
// Bit-serial perceptron controller: owns the weight/bias file, arbitrates two
// requesters and accumulates one feature bit per cycle into a signed result.
module perceptron_sequencer
    import perceptron_pkg::*;
#(
    parameter int NBITS = NBITS_DEF,
    parameter int WW    = WW_DEF,
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [3:0]       cfg_addr,
    input  logic [WW-1:0]    cfg_wdata,
    output logic             cfg_ready,
    input  logic             req0_valid,
    input  logic [NBITS-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [NBITS-1:0] req1_data,
    output logic             req1_ready,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_id,
    output logic [ACC_W-1:0] res_sum,
    output logic             res_class
);

    localparam int               IDX_W    = $clog2(NBITS);
    localparam logic [3:0]       NB_ADDR  = 4'(NBITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBITS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    function automatic logic [ACC_W-1:0] sext(input logic [WW-1:0] v);
        return {{(ACC_W - WW){v[WW-1]}}, v};
    endfunction

    state_e                   state_q, state_d;
    logic [NBITS-1:0][WW-1:0] w_q, w_d;
    logic [WW-1:0]            bias_q, bias_d;
    logic [NBITS-1:0]         data_q, data_d;
    logic                     id_q, id_d;
    logic [ACC_W-1:0]         acc_q, acc_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic                     res_valid_q, res_valid_d;
    logic                     res_id_q, res_id_d;
    logic [ACC_W-1:0]         res_sum_q, res_sum_d;
    logic                     res_class_q, res_class_d;
    logic [ACC_W-1:0]         acc_add_s;
    logic [1:0]               gnt_s;
    logic                     arb_en_s;

    // Config writes take precedence over request grants in IDLE
    assign arb_en_s   = rst_n && (state_q == IDLE) && !cfg_we;
    assign cfg_ready  = rst_n && (state_q == IDLE);
    assign req0_ready = gnt_s[0];
    assign req1_ready = gnt_s[1];

    assign res_valid = res_valid_q;
    assign res_id    = res_id_q;
    assign res_sum   = res_sum_q;
    assign res_class = res_class_q;

    rr_arbiter2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   ({req1_valid, req0_valid}),
        .en    (arb_en_s),
        .gnt   (gnt_s)
    );

    // Next-state, register-file write and accumulate step
    always_comb begin
        state_d     = state_q;
        w_d         = w_q;
        bias_d      = bias_q;
        data_d      = data_q;
        id_d        = id_q;
        acc_d       = acc_q;
        idx_d       = idx_q;
        res_valid_d = res_valid_q;
        res_id_d    = res_id_q;
        res_sum_d   = res_sum_q;
        res_class_d = res_class_q;
        acc_add_s   = acc_q + (data_q[idx_q] ? sext(w_q[idx_q]) : {ACC_W{1'b0}});

        case (state_q)
            IDLE: begin
                if (cfg_we) begin
                    if (cfg_addr < NB_ADDR) begin
                        w_d[cfg_addr[IDX_W-1:0]] = cfg_wdata;
                    end else if (cfg_addr == CFG_ADDR_BIAS) begin
                        bias_d = cfg_wdata;
                    end else begin
                        bias_d = bias_q;
                    end
                end else if (gnt_s != 2'b00) begin
                    data_d  = gnt_s[1] ? req1_data : req0_data;
                    id_d    = gnt_s[1];
                    acc_d   = sext(bias_q);
                    idx_d   = {IDX_W{1'b0}};
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                acc_d = acc_add_s;
                idx_d = idx_q + IDX_ONE;
                if (idx_q == LAST_IDX) begin
                    res_sum_d   = acc_add_s;
                    res_class_d = ~acc_add_s[ACC_W-1];
                    res_id_d    = id_q;
                    res_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    state_d = RUN;
                end
            end
            DONE: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                res_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // State, register file and result registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            w_q         <= {NBITS{WW'(W_RESET)}};
            bias_q      <= WW'(B_RESET);
            data_q      <= {NBITS{1'b0}};
            id_q        <= 1'b0;
            acc_q       <= {ACC_W{1'b0}};
            idx_q       <= {IDX_W{1'b0}};
            res_valid_q <= 1'b0;
            res_id_q    <= 1'b0;
            res_sum_q   <= {ACC_W{1'b0}};
            res_class_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            w_q         <= w_d;
            bias_q      <= bias_d;
            data_q      <= data_d;
            id_q        <= id_d;
            acc_q       <= acc_d;
            idx_q       <= idx_d;
            res_valid_q <= res_valid_d;
            res_id_q    <= res_id_d;
            res_sum_q   <= res_sum_d;
            res_class_q <= res_class_d;
        end
    end

endmodule
